tron_input_ctrl: RTL

Keyboard-to-game input stage for the tron design. It sits between `ps2_keyboard` and `game_logic`, consuming raw PS/2 scan-code strobes and producing the four player directions plus a restart pulse. It tracks the E0/F0 prefixes and maps keys to players. Each player has a short direction queue, drained one entry per game step, so that fast key sequences between steps are not lost and instant 180° reversals are rejected.

---
 rtl/tron_types.sv | 115 +++++++++++
 rtl/tron_input_ctrl_dir_queue.sv | 93 +++++++++
 rtl/tron_input_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/tron_types.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tron_types : shared directions, scan codes and key-map helpers for tron  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package tron_types;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] player;
    dir_t       dir;
  } key_map_t;

  localparam logic [7:0] KEY_E0       = 8'hE0;
  localparam logic [7:0] KEY_F0       = 8'hF0;
  localparam logic [7:0] KEY_SPACE    = 8'h29;

  localparam logic [7:0] KEY_P1_UP    = 8'h1D;
  localparam logic [7:0] KEY_P1_DOWN  = 8'h1B;
  localparam logic [7:0] KEY_P1_LEFT  = 8'h1C;
  localparam logic [7:0] KEY_P1_RIGHT = 8'h23;

  localparam logic [7:0] KEY_P2_UP    = 8'h75;
  localparam logic [7:0] KEY_P2_DOWN  = 8'h72;
  localparam logic [7:0] KEY_P2_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_P2_RIGHT = 8'h74;

  localparam logic [7:0] KEY_P3_UP    = 8'h2C;
  localparam logic [7:0] KEY_P3_DOWN  = 8'h34;
  localparam logic [7:0] KEY_P3_LEFT  = 8'h2B;
  localparam logic [7:0] KEY_P3_RIGHT = 8'h33;

  localparam logic [7:0] KEY_P4_UP    = 8'h43;
  localparam logic [7:0] KEY_P4_DOWN  = 8'h42;
  localparam logic [7:0] KEY_P4_LEFT  = 8'h3B;
  localparam logic [7:0] KEY_P4_RIGHT = 8'h4B;

  localparam dir_t DEF_D1 = DIR_RIGHT;
  localparam dir_t DEF_D2 = DIR_LEFT;
  localparam dir_t DEF_D3 = DIR_DOWN;
  localparam dir_t DEF_D4 = DIR_UP;

  function automatic dir_t opposite(input dir_t d);
    dir_t r;
    case (d)
      DIR_UP:    r = DIR_DOWN;
      DIR_DOWN:  r = DIR_UP;
      DIR_LEFT:  r = DIR_RIGHT;
      default:   r = DIR_LEFT;
    endcase
    return r;
  endfunction

  function automatic dir_t default_dir(input logic [1:0] player);
    dir_t r;
    case (player)
      2'd0:    r = DEF_D1;
      2'd1:    r = DEF_D2;
      2'd2:    r = DEF_D3;
      default: r = DEF_D4;
    endcase
    return r;
  endfunction

  function automatic key_map_t map_entry(input logic [1:0] player, input dir_t dir);
    key_map_t r;
    r.valid  = 1'b1;
    r.player = player;
    r.dir    = dir;
    return r;
  endfunction

  // Player 2 lives on the extended arrow keys; everyone else is plain.
  function automatic key_map_t decode_key(input logic [7:0] code, input logic ext);
    key_map_t r;
    r.valid  = 1'b0;
    r.player = 2'd0;
    r.dir    = DIR_UP;
    if (ext) begin
      case (code)
        KEY_P2_UP:    r = map_entry(2'd1, DIR_UP);
        KEY_P2_DOWN:  r = map_entry(2'd1, DIR_DOWN);
        KEY_P2_LEFT:  r = map_entry(2'd1, DIR_LEFT);
        KEY_P2_RIGHT: r = map_entry(2'd1, DIR_RIGHT);
        default:      r.valid = 1'b0;
      endcase
    end else begin
      case (code)
        KEY_P1_UP:    r = map_entry(2'd0, DIR_UP);
        KEY_P1_DOWN:  r = map_entry(2'd0, DIR_DOWN);
        KEY_P1_LEFT:  r = map_entry(2'd0, DIR_LEFT);
        KEY_P1_RIGHT: r = map_entry(2'd0, DIR_RIGHT);
        KEY_P3_UP:    r = map_entry(2'd2, DIR_UP);
        KEY_P3_DOWN:  r = map_entry(2'd2, DIR_DOWN);
        KEY_P3_LEFT:  r = map_entry(2'd2, DIR_LEFT);
        KEY_P3_RIGHT: r = map_entry(2'd2, DIR_RIGHT);
        KEY_P4_UP:    r = map_entry(2'd3, DIR_UP);
        KEY_P4_DOWN:  r = map_entry(2'd3, DIR_DOWN);
        KEY_P4_LEFT:  r = map_entry(2'd3, DIR_LEFT);
        KEY_P4_RIGHT: r = map_entry(2'd3, DIR_RIGHT);
        default:      r.valid = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tron_input_ctrl_dir_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dir_queue : small circular FIFO of directions, combinational head/tail   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dir_queue
  import tron_types::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push,
  input  dir_t push_dir,
  input  logic pop,
  input  logic flush,
  output dir_t head,
  output dir_t tail,
  output logic empty,
  output logic full
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(QDEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);

  dir_t             mem_q [QDEPTH];
  dir_t             mem_d [QDEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] tail_idx;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_FULL);
  assign tail_idx = (wr_q == '0) ? LAST_IDX : wr_q - PTR_W'(1);
  assign head     = mem_q[rd_q];
  assign tail     = mem_q[tail_idx];

  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_dir;
        wr_d        = next_ptr(wr_q);
      end
      if (do_pop) begin
        rd_d = next_ptr(rd_q);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= DIR_UP;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tron_input_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tron_input_ctrl : PS/2 scan codes -> queued player directions + restart  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tron_input_ctrl
  import tron_types::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_code_new,
  input  logic [7:0] ps2_code,
  input  logic       step,
  output dir_t       d1,
  output dir_t       d2,
  output dir_t       d3,
  output dir_t       d4,
  output logic       restart,
  output logic       key_drop
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       sync2_prev_q, sync2_prev_d;
  logic       strobe;
  logic [1:0] state_q, state_d;
  dir_t       d_q [4];
  dir_t       d_d [4];
  logic       restart_q, restart_d;
  logic       key_drop_q, key_drop_d;

  logic       make_ev;
  logic       brk_ev;
  logic       ext_ev;
  logic       space_make;
  logic       space_brk;
  key_map_t   km;

  logic [3:0] q_push;
  logic [3:0] q_pop;
  logic [3:0] q_empty;
  logic [3:0] q_full;
  dir_t       q_head [4];
  dir_t       q_tail [4];
  dir_t       last_dir [4];
  logic [3:0] move_ok;

  assign sync1_d      = ps2_code_new;
  assign sync2_d      = sync1_q;
  assign sync2_prev_d = sync2_q;
  assign strobe       = sync2_q & ~sync2_prev_q;

  // Prefix tracking: E0 marks extended, F0 marks a release of the next code.
  always_comb begin
    state_d = state_q;
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    ext_ev  = 1'b0;
    if (strobe) begin
      if (ps2_code == KEY_E0) begin
        if (state_q == ST_IDLE || state_q == ST_EXT) begin
          state_d = ST_EXT;
        end
      end else if (ps2_code == KEY_F0) begin
        state_d = (state_q == ST_EXT || state_q == ST_EXT_BRK) ? ST_EXT_BRK : ST_BRK;
      end else begin
        ext_ev  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        make_ev = (state_q == ST_IDLE) || (state_q == ST_EXT);
        brk_ev  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        state_d = ST_IDLE;
      end
    end
  end

  assign km         = decode_key(ps2_code, ext_ev);
  assign space_make = make_ev & ~ext_ev & (ps2_code == KEY_SPACE);
  assign space_brk  = brk_ev & ~ext_ev & (ps2_code == KEY_SPACE);
  assign restart_d  = space_brk;

  // Reversal/repeat checks compare against the newest pending direction.
  always_comb begin
    q_push     = '0;
    q_pop      = '0;
    move_ok    = '0;
    key_drop_d = 1'b0;
    for (int p = 0; p < 4; p++) begin
      last_dir[p] = q_empty[p] ? d_q[p] : q_tail[p];
      move_ok[p]  = make_ev & km.valid & (km.player == 2'(p)) &
                    (km.dir != last_dir[p]) & (km.dir != opposite(last_dir[p]));
      q_push[p]   = move_ok[p] & (~q_full[p] | step);
      q_pop[p]    = step & ~q_empty[p] & ~space_make;
      if (move_ok[p] & q_full[p] & ~step) begin
        key_drop_d = 1'b1;
      end
      if (space_make) begin
        d_d[p] = default_dir(2'(p));
      end else if (q_pop[p]) begin
        d_d[p] = q_head[p];
      end else begin
        d_d[p] = d_q[p];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_queue
    dir_queue #(
      .QDEPTH (QDEPTH)
    ) u_dir_queue (
      .clock    (clock),
      .reset_n  (reset_n),
      .push     (q_push[g]),
      .push_dir (km.dir),
      .pop      (q_pop[g]),
      .flush    (space_make),
      .head     (q_head[g]),
      .tail     (q_tail[g]),
      .empty    (q_empty[g]),
      .full     (q_full[g])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync2_prev_q <= 1'b0;
      state_q      <= ST_IDLE;
      d_q[0]       <= DEF_D1;
      d_q[1]       <= DEF_D2;
      d_q[2]       <= DEF_D3;
      d_q[3]       <= DEF_D4;
      restart_q    <= 1'b0;
      key_drop_q   <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync2_prev_q <= sync2_prev_d;
      state_q      <= state_d;
      d_q          <= d_d;
      restart_q    <= restart_d;
      key_drop_q   <= key_drop_d;
    end
  end

  assign d1       = d_q[0];
  assign d2       = d_q[1];
  assign d3       = d_q[2];
  assign d4       = d_q[3];
  assign restart  = restart_q;
  assign key_drop = key_drop_q;

endmodule
`default_nettype wire
